// File: rtl/axis_frame_fifo.sv
// AXI4-Stream frame FIFO with a first-word-fall-through head, selectable
// cut-through or store-and-forward release, and frame/fill status counters.
module axis_frame_fifo #(
  parameter int C_AXIS_TDATA_WIDTH = 24,
  parameter int C_AXIS_FIFO_DEPTH  = 16,
  parameter int C_AXIS_TUSER_WIDTH = 1,
  parameter int C_STORE_FORWARD    = 0
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      s00_axis_tvalid,
  output logic                                      s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]             s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]           s00_axis_tstrb,
  input  logic                                      s00_axis_tlast,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]             s00_axis_tuser,
  output logic                                      m00_axis_tvalid,
  input  logic                                      m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]             m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]           m00_axis_tstrb,
  output logic                                      m00_axis_tlast,
  output logic [C_AXIS_TUSER_WIDTH-1:0]             m00_axis_tuser,
  output logic [$clog2(C_AXIS_FIFO_DEPTH+1)-1:0]    fill_level,
  output logic [$clog2(C_AXIS_FIFO_DEPTH+1)-1:0]    frames_stored,
  output logic [15:0]                               frames_out,
  output logic                                      overflow_attempt
);

  localparam int CW = $clog2(C_AXIS_FIFO_DEPTH + 1);
  localparam int AW = $clog2(C_AXIS_FIFO_DEPTH);
  localparam int SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int BW = C_AXIS_TDATA_WIDTH + SW + 1 + C_AXIS_TUSER_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(C_AXIS_FIFO_DEPTH);

  // Beat storage: {tdata, tstrb, tlast, tuser}; never reset, only the
  // pointers and counters define what is valid.
  logic [BW-1:0] mem_q [C_AXIS_FIFO_DEPTH];
  logic [BW-1:0] head;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] frames_q, frames_d;
  logic [15:0]   fout_q, fout_d;
  logic          release_q, release_d;
  logic          run_q;

  logic full, wr_en, rd_en, wr_last, rd_last;

  assign full    = (fill_q == DEPTH_C);
  assign wr_en   = s00_axis_tvalid && s00_axis_tready;
  assign rd_en   = m00_axis_tvalid && m00_axis_tready;
  assign wr_last = wr_en && s00_axis_tlast;
  assign rd_last = rd_en && m00_axis_tlast;

  // Ready is purely a function of registered state; run_q keeps it low
  // until the first clock edge after reset release.
  assign s00_axis_tready  = run_q && !full;
  assign overflow_attempt = run_q && s00_axis_tvalid && !s00_axis_tready;

  // Head of queue is read asynchronously so it is visible the cycle after it is written.
  assign head = mem_q[rd_ptr_q];
  assign {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, m00_axis_tuser} = head;

  assign fill_level    = fill_q;
  assign frames_stored = frames_q;
  assign frames_out    = fout_q;

  // Output valid: cut-through shows any stored beat; store-and-forward waits for
  // a complete frame, or for a full FIFO (latched in release_q until that frame's tlast leaves).
  always_comb begin
    m00_axis_tvalid = 1'b0;
    if (C_STORE_FORWARD == 0) begin
      m00_axis_tvalid = (fill_q != '0);
    end else begin
      m00_axis_tvalid = (fill_q != '0) && ((frames_q != '0) || full || release_q);
    end
  end

  // Next-state for pointers, occupancy, frame counters and the oversize-frame release latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    frames_d  = frames_q;
    fout_d    = fout_q;
    release_d = release_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase

    case ({wr_last, rd_last})
      2'b10:   frames_d = frames_q + CW'(1);
      2'b01:   frames_d = frames_q - CW'(1);
      default: frames_d = frames_q;
    endcase

    if (rd_last) fout_d = fout_q + 16'd1;

    // A frame longer than the FIFO would otherwise never show a tlast; once
    // the FIFO fills with no complete frame, keep draining until that tlast leaves.
    if (C_STORE_FORWARD != 0) begin
      if (rd_last) begin
        release_d = 1'b0;
      end else if (full && (frames_q == '0)) begin
        release_d = 1'b1;
      end
    end else begin
      release_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      frames_q  <= '0;
      fout_q    <= '0;
      release_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      frames_q  <= frames_d;
      fout_q    <= fout_d;
      release_q <= release_d;
      run_q     <= 1'b1;
    end
  end

  // Beat storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tuser};
    end
  end

endmodule
